// File: rtl/game_pkg.sv
// game_pkg
//   Shared constants and types for the game video pipeline: screen size,
//   sprite dimensions, default object counts and the collision detector's
//   state encoding. Imported by bullet_collision_detector and box_overlap.
package game_pkg;

  // Visible screen area in pixels.
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Sprite bounding-box sizes in pixels.
  localparam int BULLET_SPRITE_W = 2;
  localparam int BULLET_SPRITE_H = 4;
  localparam int ENEMY_SPRITE_W  = 16;
  localparam int ENEMY_SPRITE_H  = 16;

  // Default object counts on the flat position buses.
  localparam int DEFAULT_BULLET_COUNT = 8;
  localparam int DEFAULT_ENEMY_COUNT  = 4;

  // Collision detector state encoding.
  typedef enum logic [1:0] {
    DET_IDLE   = 2'd0,
    DET_SCAN   = 2'd1,
    DET_REPORT = 2'd2
  } det_state_t;

endpackage

// File: rtl/box_overlap.sv
// box_overlap
//   Combinational axis-aligned bounding-box test between box A and box B,
//   both given by 10-bit top-left corners. Sizes are parameters. Edge
//   contact does not count as overlap (strict inequalities). All sums are
//   formed at 11 bits so corners near 1023 do not wrap.
// Ports:
//   a_x, a_y  in  10  top-left corner of box A (size A_W x A_H)
//   b_x, b_y  in  10  top-left corner of box B (size B_W x B_H)
//   overlap   out 1   boxes share at least one pixel
module box_overlap
  import game_pkg::*;
#(
  parameter int A_W = BULLET_SPRITE_W,
  parameter int A_H = BULLET_SPRITE_H,
  parameter int B_W = ENEMY_SPRITE_W,
  parameter int B_H = ENEMY_SPRITE_H
) (
  input  logic [9:0] a_x,
  input  logic [9:0] a_y,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  output logic       overlap
);

  logic [10:0] ax;
  logic [10:0] ay;
  logic [10:0] bx;
  logic [10:0] by;

  assign ax = {1'b0, a_x};
  assign ay = {1'b0, a_y};
  assign bx = {1'b0, b_x};
  assign by = {1'b0, b_y};

  assign overlap = (ax < bx + 11'(B_W)) &&
                   (ax + 11'(A_W) > bx) &&
                   (ay < by + 11'(B_H)) &&
                   (ay + 11'(A_H) > by);

endmodule

// File: rtl/bullet_collision_detector.sv
// bullet_collision_detector
//   Per-frame bullet/enemy collision checker. On start_scan (in IDLE) it
//   snapshots all position buses, walks every (bullet, enemy) pair one per
//   cycle (enemy index is the inner loop), and then reports one-cycle
//   bullet_hit / enemy_hit / scan_done pulses. A bullet kills at most one
//   enemy and an enemy absorbs at most one bullet per scan; lowest bullet
//   index wins, then lowest enemy index.
//   Optional feature macro: COLLISION_SCORE_EN -- when defined, a saturating
//   kill counter drives score; when undefined, score is tied to 0.
// Ports:
//   clk25               in   1           pixel clock
//   rst                 in   1           asynchronous active-high reset
//   start_scan          in   1           frame tick, accepted only in IDLE
//   bullet_x_flat       in   10*BC       bullet i x at [i*10 +: 10]
//   bullet_y_flat       in   10*BC       bullet i y at [i*10 +: 10]
//   bullet_active_flat  in   BC          bullet valid
//   enemy_x_flat        in   10*EC       enemy i x at [i*10 +: 10]
//   enemy_y_flat        in   10*EC       enemy i y at [i*10 +: 10]
//   enemy_alive_flat    in   EC          enemy valid
//   bullet_hit          out  BC          one-cycle pulse per consumed bullet
//   enemy_hit           out  EC          one-cycle pulse per killed enemy
//   scan_done           out  1           one-cycle pulse, results valid
//   busy                out  1           snapshot cycle through REPORT
//   score               out  SCORE_W     saturating kill count
module bullet_collision_detector
  import game_pkg::*;
#(
  parameter int BULLET_COUNT = DEFAULT_BULLET_COUNT,
  parameter int ENEMY_COUNT  = DEFAULT_ENEMY_COUNT,
  parameter int BULLET_W     = BULLET_SPRITE_W,
  parameter int BULLET_H     = BULLET_SPRITE_H,
  parameter int ENEMY_W      = ENEMY_SPRITE_W,
  parameter int ENEMY_H      = ENEMY_SPRITE_H,
  parameter int SCORE_W      = 16
) (
  input  logic                      clk25,
  input  logic                      rst,
  input  logic                      start_scan,
  input  logic [10*BULLET_COUNT-1:0] bullet_x_flat,
  input  logic [10*BULLET_COUNT-1:0] bullet_y_flat,
  input  logic [BULLET_COUNT-1:0]    bullet_active_flat,
  input  logic [10*ENEMY_COUNT-1:0]  enemy_x_flat,
  input  logic [10*ENEMY_COUNT-1:0]  enemy_y_flat,
  input  logic [ENEMY_COUNT-1:0]     enemy_alive_flat,
  output logic [BULLET_COUNT-1:0]    bullet_hit,
  output logic [ENEMY_COUNT-1:0]     enemy_hit,
  output logic                      scan_done,
  output logic                      busy,
  output logic [SCORE_W-1:0]        score
);

  localparam int BI_W = (BULLET_COUNT > 1) ? $clog2(BULLET_COUNT) : 1;
  localparam int EI_W = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1;
  localparam logic [BI_W-1:0] B_LAST = BI_W'(BULLET_COUNT - 1);
  localparam logic [EI_W-1:0] E_LAST = EI_W'(ENEMY_COUNT - 1);

  det_state_t state_reg;
  det_state_t state_next;

  // Snapshot of the input buses, taken on the accepting start_scan edge.
  logic [10*BULLET_COUNT-1:0] bx_snap_reg;
  logic [10*BULLET_COUNT-1:0] by_snap_reg;
  logic [BULLET_COUNT-1:0]    bact_snap_reg;
  logic [10*ENEMY_COUNT-1:0]  ex_snap_reg;
  logic [10*ENEMY_COUNT-1:0]  ey_snap_reg;
  logic [ENEMY_COUNT-1:0]     ealive_snap_reg;

  logic [BI_W-1:0]         b_idx_reg;
  logic [EI_W-1:0]         e_idx_reg;
  logic [BULLET_COUNT-1:0] b_used_reg;
  logic [ENEMY_COUNT-1:0]  e_used_reg;

  logic [BULLET_COUNT-1:0] bullet_hit_reg;
  logic [ENEMY_COUNT-1:0]  enemy_hit_reg;
  logic                    scan_done_reg;
  logic                    busy_reg;

  // Unpacked views of the snapshot so the current pair can be muxed by index.
  logic [9:0] bx_arr [BULLET_COUNT];
  logic [9:0] by_arr [BULLET_COUNT];
  logic [9:0] ex_arr [ENEMY_COUNT];
  logic [9:0] ey_arr [ENEMY_COUNT];

  genvar gi;
  generate
    for (gi = 0; gi < BULLET_COUNT; gi++) begin : g_bullet_unpack
      assign bx_arr[gi] = bx_snap_reg[gi*10 +: 10];
      assign by_arr[gi] = by_snap_reg[gi*10 +: 10];
    end
    for (gi = 0; gi < ENEMY_COUNT; gi++) begin : g_enemy_unpack
      assign ex_arr[gi] = ex_snap_reg[gi*10 +: 10];
      assign ey_arr[gi] = ey_snap_reg[gi*10 +: 10];
    end
  endgenerate

  logic pair_overlap;
  logic pair_hit;
  logic last_pair;

  box_overlap #(
    .A_W (BULLET_W),
    .A_H (BULLET_H),
    .B_W (ENEMY_W),
    .B_H (ENEMY_H)
  ) u_box_overlap (
    .a_x     (bx_arr[b_idx_reg]),
    .a_y     (by_arr[b_idx_reg]),
    .b_x     (ex_arr[e_idx_reg]),
    .b_y     (ey_arr[e_idx_reg]),
    .overlap (pair_overlap)
  );

  // A pair only counts if neither side was already consumed earlier in this
  // scan; that is what gives lowest-bullet-then-lowest-enemy priority.
  assign pair_hit = bact_snap_reg[b_idx_reg] && ealive_snap_reg[e_idx_reg] &&
                    !b_used_reg[b_idx_reg] && !e_used_reg[e_idx_reg] &&
                    pair_overlap;

  assign last_pair = (b_idx_reg == B_LAST) && (e_idx_reg == E_LAST);

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_reg <= DET_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DET_IDLE:   if (start_scan) state_next = DET_SCAN;
      DET_SCAN:   if (last_pair) state_next = DET_REPORT;
      DET_REPORT: state_next = DET_IDLE;
      default:    state_next = DET_IDLE;
    endcase
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      bx_snap_reg     <= '0;
      by_snap_reg     <= '0;
      bact_snap_reg   <= '0;
      ex_snap_reg     <= '0;
      ey_snap_reg     <= '0;
      ealive_snap_reg <= '0;
      b_idx_reg       <= '0;
      e_idx_reg       <= '0;
      b_used_reg      <= '0;
      e_used_reg      <= '0;
      bullet_hit_reg  <= '0;
      enemy_hit_reg   <= '0;
      scan_done_reg   <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      bullet_hit_reg <= '0;
      enemy_hit_reg  <= '0;
      scan_done_reg  <= 1'b0;
      case (state_reg)
        DET_IDLE: begin
          busy_reg <= start_scan;
          if (start_scan) begin
            bx_snap_reg     <= bullet_x_flat;
            by_snap_reg     <= bullet_y_flat;
            bact_snap_reg   <= bullet_active_flat;
            ex_snap_reg     <= enemy_x_flat;
            ey_snap_reg     <= enemy_y_flat;
            ealive_snap_reg <= enemy_alive_flat;
            b_used_reg      <= '0;
            e_used_reg      <= '0;
            b_idx_reg       <= '0;
            e_idx_reg       <= '0;
          end
        end
        DET_SCAN: begin
          if (pair_hit) begin
            b_used_reg[b_idx_reg] <= 1'b1;
            e_used_reg[e_idx_reg] <= 1'b1;
          end
          if (e_idx_reg == E_LAST) begin
            e_idx_reg <= '0;
            b_idx_reg <= b_idx_reg + BI_W'(1);
          end else begin
            e_idx_reg <= e_idx_reg + EI_W'(1);
          end
        end
        DET_REPORT: begin
          bullet_hit_reg <= b_used_reg;
          enemy_hit_reg  <= e_used_reg;
          scan_done_reg  <= 1'b1;
        end
        default: begin
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bullet_hit = bullet_hit_reg;
  assign enemy_hit  = enemy_hit_reg;
  assign scan_done  = scan_done_reg;
  assign busy       = busy_reg;

`ifdef COLLISION_SCORE_EN
  localparam int KW    = $clog2(ENEMY_COUNT + 1);
  localparam int SUM_W = SCORE_W + KW;

  logic [KW-1:0]      kills;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_reg;

  always_comb begin
    kills = '0;
    for (int i = 0; i < ENEMY_COUNT; i++) begin
      kills = kills + KW'(e_used_reg[i]);
    end
  end

  // Extra headroom bits let the saturation test see the true sum.
  assign score_sum = SUM_W'(score_reg) + SUM_W'(kills);

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      score_reg <= '0;
    end else if (state_reg == DET_REPORT) begin
      if (score_sum > SUM_W'({SCORE_W{1'b1}})) begin
        score_reg <= '1;
      end else begin
        score_reg <= score_sum[SCORE_W-1:0];
      end
    end
  end

  assign score = score_reg;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_bullet_collision_detector.sv
// tb_bullet_collision_detector
//   Directed self-checking bench for bullet_collision_detector. Two
//   instances share stimulus: the default one (SCORE_W=16) and a narrow one
//   (SCORE_W=4) used to observe score saturation. Expected score follows
//   COLLISION_SCORE_EN the same way the design does.
module tb_bullet_collision_detector;

  logic        clk25 = 1'b0;
  logic        rst = 1'b1;
  logic        start_scan = 1'b0;
  logic [79:0] bx_flat;
  logic [79:0] by_flat;
  logic [7:0]  bact;
  logic [39:0] ex_flat;
  logic [39:0] ey_flat;
  logic [3:0]  ealive;

  logic [7:0]  bullet_hit;
  logic [3:0]  enemy_hit;
  logic        scan_done;
  logic        busy;
  logic [15:0] score;

  logic [7:0]  bullet_hit4;
  logic [3:0]  enemy_hit4;
  logic        scan_done4;
  logic        busy4;
  logic [3:0]  score4;

  int total = 0;
  int bad = 0;
  int kills = 0;

  always #20 clk25 = ~clk25;

  bullet_collision_detector dut (
    .clk25(clk25), .rst(rst), .start_scan(start_scan),
    .bullet_x_flat(bx_flat), .bullet_y_flat(by_flat), .bullet_active_flat(bact),
    .enemy_x_flat(ex_flat), .enemy_y_flat(ey_flat), .enemy_alive_flat(ealive),
    .bullet_hit(bullet_hit), .enemy_hit(enemy_hit), .scan_done(scan_done),
    .busy(busy), .score(score)
  );

  bullet_collision_detector #(.SCORE_W(4)) dut4 (
    .clk25(clk25), .rst(rst), .start_scan(start_scan),
    .bullet_x_flat(bx_flat), .bullet_y_flat(by_flat), .bullet_active_flat(bact),
    .enemy_x_flat(ex_flat), .enemy_y_flat(ey_flat), .enemy_alive_flat(ealive),
    .bullet_hit(bullet_hit4), .enemy_hit(enemy_hit4), .scan_done(scan_done4),
    .busy(busy4), .score(score4)
  );

  function automatic logic [15:0] exp_s16();
`ifdef COLLISION_SCORE_EN
    return (kills > 65535) ? 16'hFFFF : 16'(kills);
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [3:0] exp_s4();
`ifdef COLLISION_SCORE_EN
    return (kills > 15) ? 4'hF : 4'(kills);
`else
    return 4'd0;
`endif
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic clear_objs();
    bx_flat = '0; by_flat = '0; bact = '0;
    ex_flat = '0; ey_flat = '0; ealive = '0;
  endtask

  task automatic set_bullet(input int i, input int x, input int y);
    bx_flat[i*10 +: 10] = 10'(x);
    by_flat[i*10 +: 10] = 10'(y);
    bact[i] = 1'b1;
  endtask

  task automatic set_enemy(input int i, input int x, input int y);
    ex_flat[i*10 +: 10] = 10'(x);
    ey_flat[i*10 +: 10] = 10'(y);
    ealive[i] = 1'b1;
  endtask

  // Pulses start_scan so it is sampled at T0; returns at the negedge after T0.
  task automatic kick();
    @(negedge clk25);
    start_scan = 1'b1;
    @(negedge clk25);
    start_scan = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk25);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_objs();
    rst = 1'b1;
    step(3);
    total++; if (bullet_hit !== 8'h00) begin bad++; $display("FAIL reset_bullet_hit got=%h exp=00", bullet_hit); end
    total++; if (enemy_hit !== 4'h0) begin bad++; $display("FAIL reset_enemy_hit got=%h exp=0", enemy_hit); end
    total++; if (scan_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_flags got done=%b busy=%b exp=0/0", scan_done, busy); end
    total++; if (score !== 16'd0 || score4 !== 4'd0) begin bad++; $display("FAIL reset_score got=%0d/%0d exp=0/0", score, score4); end
    rst = 1'b0;
    step(2);
    $display("reset: busy=%b score=%0d", busy, score);
  endtask

  task automatic test_basic_hit();
    logic [15:0] prev;
    clear_objs();
    set_bullet(0, 100, 100);
    set_enemy(0, 95, 90);
    prev = exp_s16();
    kick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_t0 got=%b exp=1", busy); end
    step(32);
    total++; if (scan_done !== 1'b0 || score !== prev) begin bad++; $display("FAIL basic_t32 got done=%b score=%0d exp done=0 score=%0d", scan_done, score, prev); end
    step(1);
    kills += 1;
    total++; if (bullet_hit !== 8'h01) begin bad++; $display("FAIL basic_bullet_hit got=%h exp=01", bullet_hit); end
    total++; if (enemy_hit !== 4'h1) begin bad++; $display("FAIL basic_enemy_hit got=%h exp=1", enemy_hit); end
    total++; if (scan_done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL basic_t33_flags got done=%b busy=%b exp=1/1", scan_done, busy); end
    total++; if (score !== exp_s16()) begin bad++; $display("FAIL basic_score got=%0d exp=%0d", score, exp_s16()); end
    $display("scan basic: bullet_hit=%h enemy_hit=%h score=%0d", bullet_hit, enemy_hit, score);
    step(1);
    total++; if (scan_done !== 1'b0 || busy !== 1'b0 || bullet_hit !== 8'h00) begin bad++; $display("FAIL basic_t34 got done=%b busy=%b bh=%h exp=0/0/00", scan_done, busy, bullet_hit); end
  endtask

  task automatic test_edge_contact();
    clear_objs();
    set_enemy(0, 95, 90);
    set_bullet(0, 111, 100);   // bx == ex+16
    set_bullet(1, 100, 106);   // by == ey+16
    set_bullet(2, 93, 100);    // bx+2 == ex
    set_bullet(3, 100, 86);    // by+4 == ey
    set_bullet(4, 110, 105);   // one pixel inside the corner
    set_enemy(3, 1015, 1015);
    set_bullet(6, 1020, 1020); // needs 11-bit sums to see the overlap
    kick();
    step(33);
    kills += 2;
    total++; if (bullet_hit !== 8'h50) begin bad++; $display("FAIL edge_bullet_hit got=%h exp=50", bullet_hit); end
    total++; if (enemy_hit !== 4'h9) begin bad++; $display("FAIL edge_enemy_hit got=%h exp=9", enemy_hit); end
    total++; if (score !== exp_s16()) begin bad++; $display("FAIL edge_score got=%0d exp=%0d", score, exp_s16()); end
    $display("scan edge: bullet_hit=%h enemy_hit=%h score=%0d", bullet_hit, enemy_hit, score);
    step(1);
  endtask

  task automatic test_priority();
    clear_objs();
    set_enemy(1, 200, 200);
    set_bullet(2, 205, 205);
    set_bullet(5, 205, 205);
    kick();
    step(33);
    kills += 1;
    total++; if (bullet_hit !== 8'h04) begin bad++; $display("FAIL prio_bullet_hit got=%h exp=04", bullet_hit); end
    total++; if (enemy_hit !== 4'h2) begin bad++; $display("FAIL prio_enemy_hit got=%h exp=2", enemy_hit); end
    total++; if (score !== exp_s16()) begin bad++; $display("FAIL prio_score got=%0d exp=%0d", score, exp_s16()); end
    $display("scan priority: bullet_hit=%h enemy_hit=%h score=%0d", bullet_hit, enemy_hit, score);
    step(1);
  endtask

  task automatic test_snapshot_ignore();
    clear_objs();
    set_bullet(0, 300, 300);
    set_enemy(2, 295, 295);
    kick();
    step(5);
    bact = '0;                  // live bullet disappears mid-scan
    ex_flat[2*10 +: 10] = 10'd600;
    step(4);
    start_scan = 1'b1;          // sampled at T10, must be ignored
    step(1);
    start_scan = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL snap_busy_t10 got=%b exp=1", busy); end
    step(23);
    kills += 1;
    total++; if (bullet_hit !== 8'h01 || enemy_hit !== 4'h4) begin bad++; $display("FAIL snap_hits got bh=%h eh=%h exp=01/4", bullet_hit, enemy_hit); end
    total++; if (scan_done !== 1'b1) begin bad++; $display("FAIL snap_done got=%b exp=1", scan_done); end
    $display("scan snapshot: bullet_hit=%h enemy_hit=%h score=%0d", bullet_hit, enemy_hit, score);
    step(3);
    total++; if (busy !== 1'b0 || scan_done !== 1'b0) begin bad++; $display("FAIL snap_not_queued got busy=%b done=%b exp=0/0", busy, scan_done); end
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    clear_objs();
    set_bullet(0, 100, 100);
    set_enemy(0, 95, 90);
    kick();
    step(14);
    rst = 1'b1;
    #1;
    kills = 0;
    total++; if (busy !== 1'b0 || scan_done !== 1'b0) begin bad++; $display("FAIL rstmid_flags got busy=%b done=%b exp=0/0", busy, scan_done); end
    total++; if (score !== 16'd0 || score4 !== 4'd0) begin bad++; $display("FAIL rstmid_score got=%0d/%0d exp=0/0", score, score4); end
    step(2);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk25);
      if (scan_done === 1'b1 || busy === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_pulse got=%0d active cycles exp=0", seen); end
    kick();
    step(32);
    total++; if (scan_done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rstmid_t32 got done=%b busy=%b exp=0/1", scan_done, busy); end
    step(1);
    kills += 1;
    total++; if (scan_done !== 1'b1 || bullet_hit !== 8'h01 || enemy_hit !== 4'h1) begin bad++; $display("FAIL rstmid_t33 got done=%b bh=%h eh=%h exp=1/01/1", scan_done, bullet_hit, enemy_hit); end
    total++; if (score !== exp_s16()) begin bad++; $display("FAIL rstmid_score_t33 got=%0d exp=%0d", score, exp_s16()); end
    $display("scan after reset: bullet_hit=%h enemy_hit=%h score=%0d", bullet_hit, enemy_hit, score);
    step(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_t34_busy got=%b exp=0", busy); end
  endtask

  task automatic test_saturation();
    logic [3:0] alive_tab [5];
    logic [3:0] exp_e;
    int n;
    alive_tab[0] = 4'hF; alive_tab[1] = 4'hF; alive_tab[2] = 4'hF;
    alive_tab[3] = 4'h1; alive_tab[4] = 4'h7;
    for (int s = 0; s < 5; s++) begin
      clear_objs();
      for (int i = 0; i < 4; i++) begin
        set_bullet(i, i*100 + 5, 55);
        set_enemy(i, i*100, 50);
      end
      ealive = alive_tab[s];
      exp_e = alive_tab[s];
      n = 0;
      for (int i = 0; i < 4; i++) n += int'(exp_e[i]);
      kick();
      step(33);
      kills += n;
      total++; if (bullet_hit !== {4'h0, exp_e} || enemy_hit !== exp_e) begin bad++; $display("FAIL sat_hits scan=%0d got bh=%h eh=%h exp=%h/%h", s, bullet_hit, enemy_hit, {4'h0, exp_e}, exp_e); end
      total++; if (score4 !== exp_s4()) begin bad++; $display("FAIL sat_score4 scan=%0d got=%0d exp=%0d", s, score4, exp_s4()); end
      total++; if (score !== exp_s16()) begin bad++; $display("FAIL sat_score16 scan=%0d got=%0d exp=%0d", s, score, exp_s16()); end
      $display("scan sat %0d: enemy_hit=%h score=%0d score4=%0d", s, enemy_hit, score, score4);
      step(1);
    end
  endtask

  initial begin
    clear_objs();
    test_reset();
    test_basic_hit();
    test_edge_contact();
    test_priority();
    test_snapshot_ignore();
    test_reset_mid_scan();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bullet_collision_detector.md
# bullet_collision_detector

Per-frame collision checker that closes the loop for the player bullet controller: it snapshots the bullet and enemy position buses, scans every bullet/enemy pair sequentially, and returns one-cycle `bullet_hit` and `enemy_hit` pulses plus a running kill score. It sits between the bullet controller, the enemy controller and the HUD. It is triggered once per frame, typically from the vsync start-of-blanking tick.

## Interface
- BULLET_COUNT, 8: bullets on the flat buses.
- ENEMY_COUNT, 4: enemies on the flat buses.
- BULLET_W, 2 / BULLET_H, 4: bullet box size in pixels.
- ENEMY_W, 16 / ENEMY_H, 16: enemy box size in pixels.
- SCORE_W, 16: score counter width.

Ports:
- clk25  in  1  pixel clock, 25 MHz.
- rst  in  1  asynchronous, active-high reset.
- start_scan  in  1  frame tick; starts a scan when sampled high in IDLE.
- bullet_x_flat  in  10*BULLET_COUNT  bullet top-left x, bullet i at [i*10 +: 10].
- bullet_y_flat  in  10*BULLET_COUNT  bullet top-left y.
- bullet_active_flat  in  BULLET_COUNT  bullet valid.
- enemy_x_flat  in  10*ENEMY_COUNT  enemy top-left x.
- enemy_y_flat  in  10*ENEMY_COUNT  enemy top-left y.
- enemy_alive_flat  in  ENEMY_COUNT  enemy valid.
- bullet_hit  out  BULLET_COUNT  one-cycle pulse per consumed bullet; drives the bullet controller's `bullet_hit`.
- enemy_hit  out  ENEMY_COUNT  one-cycle pulse per killed enemy.
- scan_done  out  1  one-cycle pulse when the results are valid.
- busy  out  1  high from the snapshot cycle through the REPORT cycle.
- score  out  SCORE_W  saturating kill count.

## Operation
- States: IDLE, SCAN, REPORT.
- IDLE, start_scan=1:
  - Register all six input buses into a snapshot.
  - Clear the `b_used` and `e_used` masks.
  - Set b=0, e=0. Go to SCAN.
- SCAN: one pair (b,e) is evaluated per cycle, e is the inner loop. A pair hits when all of these hold:
  - Snapshot bullet b is active and enemy e is alive.
  - `b_used[b]` and `e_used[e]` are both 0.
  - The boxes overlap: bx < ex+ENEMY_W, bx+BULLET_W > ex, by < ey+ENEMY_H, by+BULLET_H > ey.
- All overlap sums are computed at 11 bits, so coordinates near 1023 do not wrap.
- Edge contact is not a hit; the inequalities are strict.
- On a hit, set `b_used[b]` and `e_used[e]`. One bullet kills at most one enemy, and one enemy absorbs at most one bullet per scan.
- Priority within a scan is lowest bullet index first, then lowest enemy index.
- After pair (BULLET_COUNT-1, ENEMY_COUNT-1), go to REPORT.
- REPORT: for one cycle, bullet_hit=b_used, enemy_hit=e_used, scan_done=1, and score += popcount(e_used), saturating at all-ones. Then return to IDLE.
- start_scan while busy is ignored and not queued.
- Live input changes during a scan are ignored; only the snapshot is used.
- Reset values: state IDLE, every output 0, score 0.
- Reset mid-scan aborts the scan with no pulse emitted.

## Timing
- N = BULLET_COUNT*ENEMY_COUNT, which is 32 by default.
- start_scan sampled at edge T0. Pairs are evaluated at edges T1..TN. REPORT is entered at TN.
- bullet_hit, enemy_hit and scan_done are high for exactly the cycle between edges TN+1 and TN+2. score updates at TN+1.
- busy rises at T0 and falls at TN+2. The next start_scan is accepted at TN+2 or later.
- The default scan takes 34 cycles, far shorter than the bullet move period of 2^16 cycles, so the snapshot is never stale.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- COLLISION_SCORE_EN defined: score counter present and behaving as above.
- COLLISION_SCORE_EN undefined: no counter or popcount logic, and score is tied to 0. Hit and scan behaviour is unchanged.

## Structure
- Shared package `game_pkg`:
  - Screen constants (640x480).
  - Sprite dimension constants.
  - Default BULLET_COUNT and ENEMY_COUNT.
  - The detector state encoding (IDLE/SCAN/REPORT).
- Sub-module `box_overlap`: combinational AABB test on two 10-bit boxes, with widths and heights as parameters and a 1-bit overlap output.

## Test plan
- Bullet 0 at (100,100), active; enemy 0 at (95,90), alive; start_scan -> at T33, bullet_hit=0x01, enemy_hit=0x1, scan_done=1, score=1.
- Bullet at (111,100) against enemy at (95,90): bx equals ex+16, edge contact only -> at T33, bullet_hit=0, enemy_hit=0, score unchanged.
- Bullets 2 and 5 both overlapping enemy 1 -> bullet_hit=0x04, enemy_hit=0x2 (lowest bullet index wins); bullet 5 survives.
- Overlapping pair, but the bullet goes inactive at T5 mid-scan -> hit still reported from the snapshot; a second start_scan at T10 is ignored, busy=1.
- rst asserted at T15 mid-scan -> outputs 0 immediately, no scan_done pulse, and the next start_scan gives a full 34-cycle scan.
- Score preset near max (SCORE_W=4, 14 kills), then 3 kills in one scan -> score=15 (saturates); with COLLISION_SCORE_EN undefined, score=0 throughout.
